// File: rtl/serial_capture_arb.sv
// serial_capture_arb
// Two-requester serial capture engine. A round-robin arbiter grants one
// requester, eight serial bits are shifted in LSB first from that requester,
// and the completed word is held for a ready/valid handshake downstream.
// A requester dropping its request mid-capture cancels the capture.
module serial_capture_arb (
    input  logic       iClk,
    input  logic       iReset,
    input  logic [1:0] iReq,
    input  logic       iSignal0,
    input  logic       iSignal1,
    input  logic       iReady,
    output logic [1:0] oGrant,
    output logic [2:0] oBitIdx,
    output logic [7:0] oVector,
    output logic       oSrc,
    output logic       oValid,
    output logic       oAbort
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;

    logic [1:0] state;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic       prioPtr;
    logic [1:0] nextGrant;
    logic [7:0] nextShift;
    logic       grantIdx;
    logic       grantedSig;
    logic       grantedReq;

    // Pick the requester to grant; on a tie the priority pointer decides,
    // and it always points at the requester that was not served last.
    always_comb begin
        nextGrant = iReq;
        if (iReq == 2'b11) begin
            nextGrant = prioPtr ? 2'b10 : 2'b01;
        end
    end

    // Decode the current grant into the selected serial line and request bit,
    // and form the shift register value including the bit sampled this edge.
    always_comb begin
        grantIdx   = oGrant[1];
        grantedSig = grantIdx ? iSignal1 : iSignal0;
        grantedReq = |(oGrant & iReq);
        nextShift  = shiftReg;
        nextShift[bitCnt] = grantedSig;
    end

    // Status outputs derived from state so they follow reset without a clock.
    always_comb begin
        oValid  = (state == DELIVER);
        oBitIdx = (state == SHIFT) ? bitCnt : 3'd0;
    end

    // Main sequencer: arbitrate in IDLE, shift eight bits, then hold the word
    // until downstream takes it. The pointer only moves on a finished delivery.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state    <= IDLE;
            oGrant   <= 2'b00;
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
            oVector  <= 8'h00;
            oSrc     <= 1'b0;
            oAbort   <= 1'b0;
            prioPtr  <= 1'b0;
        end else begin
            oAbort <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReq != 2'b00) begin
                        oGrant   <= nextGrant;
                        bitCnt   <= 3'd0;
                        shiftReg <= 8'h00;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!grantedReq) begin
                        state  <= IDLE;
                        oGrant <= 2'b00;
                        bitCnt <= 3'd0;
                        oAbort <= 1'b1;
                    end else begin
                        shiftReg <= nextShift;
                        if (bitCnt == 3'd7) begin
                            state   <= DELIVER;
                            oVector <= nextShift;
                            oSrc    <= grantIdx;
                            oGrant  <= 2'b00;
                            bitCnt  <= 3'd0;
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                        end
                    end
                end
                DELIVER: begin
                    if (iReady) begin
                        state   <= IDLE;
                        prioPtr <= ~oSrc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_capture_arb.sv
// tb_serial_capture_arb
// Directed bench for serial_capture_arb. Expected words are queued when a
// capture is started and popped when the DUT raises oValid.
module tb_serial_capture_arb;

    logic       iClk = 1'b0;
    logic       iReset;
    logic [1:0] iReq;
    logic       iSignal0;
    logic       iSignal1;
    logic       iReady;
    logic [1:0] oGrant;
    logic [2:0] oBitIdx;
    logic [7:0] oVector;
    logic       oSrc;
    logic       oValid;
    logic       oAbort;

    int passCount  = 0;
    int totalCount = 0;
    int failCount  = 0;
    logic [8:0] sbQueue[$];

    serial_capture_arb dut (
        .iClk     (iClk),
        .iReset   (iReset),
        .iReq     (iReq),
        .iSignal0 (iSignal0),
        .iSignal1 (iSignal1),
        .iReady   (iReady),
        .oGrant   (oGrant),
        .oBitIdx  (oBitIdx),
        .oVector  (oVector),
        .oSrc     (oSrc),
        .oValid   (oValid),
        .oAbort   (oAbort)
    );

    // Free-running 100 MHz clock.
    always #5 iClk = ~iClk;

    // Safety net so a stuck run still ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the edge.
    task automatic stepClk();
        @(posedge iClk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".grant"},  32'(oGrant),  32'(2'b00));
        checkOutput({tag, ".bitIdx"}, 32'(oBitIdx), 32'(3'd0));
        checkOutput({tag, ".vector"}, 32'(oVector), 32'(8'h00));
        checkOutput({tag, ".src"},    32'(oSrc),    32'(1'b0));
        checkOutput({tag, ".valid"},  32'(oValid),  32'(1'b0));
        checkOutput({tag, ".abort"},  32'(oAbort),  32'(1'b0));
    endtask

    // Run one complete capture and delivery, starting from IDLE aligned just
    // after an edge. readyDelay cycles of backpressure precede iReady.
    task automatic applyStimulus(input logic [1:0] req, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic expSrc, input int readyDelay);
        logic [7:0] expData;
        logic [1:0] expGrant;
        logic [8:0] expWord;
        expData  = expSrc ? d1 : d0;
        expGrant = expSrc ? 2'b10 : 2'b01;
        sbQueue.push_back({expSrc, expData});
        iReq   = req;
        iReady = 1'b0;
        stepClk();
        for (int i = 0; i < 8; i++) begin
            iSignal0 = d0[i];
            iSignal1 = d1[i];
            checkOutput("shift.grant",  32'(oGrant),  32'(expGrant));
            checkOutput("shift.bitIdx", 32'(oBitIdx), 32'(i));
            checkOutput("shift.valid",  32'(oValid),  32'(1'b0));
            checkOutput("shift.abort",  32'(oAbort),  32'(1'b0));
            stepClk();
        end
        checkOutput("deliver.valid", 32'(oValid), 32'(1'b1));
        checkOutput("deliver.grant", 32'(oGrant), 32'(2'b00));
        checkOutput("sb.notEmpty", 32'(sbQueue.size() != 0), 32'(1'b1));
        expWord = 9'h000;
        if (sbQueue.size() != 0) begin
            expWord = sbQueue.pop_front();
        end
        checkOutput("deliver.vector", 32'(oVector), 32'(expWord[7:0]));
        checkOutput("deliver.src",    32'(oSrc),    32'(expWord[8]));
        for (int k = 0; k < readyDelay; k++) begin
            stepClk();
            checkOutput("hold.valid",  32'(oValid),  32'(1'b1));
            checkOutput("hold.vector", 32'(oVector), 32'(expWord[7:0]));
            checkOutput("hold.src",    32'(oSrc),    32'(expWord[8]));
            checkOutput("hold.grant",  32'(oGrant),  32'(2'b00));
        end
        iReady = 1'b1;
        stepClk();
        iReady = 1'b0;
        checkOutput("exit.valid",  32'(oValid),  32'(1'b0));
        checkOutput("exit.grant",  32'(oGrant),  32'(2'b00));
        checkOutput("exit.vector", 32'(oVector), 32'(expWord[7:0]));
    endtask

    // Directed sequence: reset, round-robin, backpressure, abort, async reset.
    initial begin
        iReset   = 1'b1;
        iReq     = 2'b00;
        iSignal0 = 1'b0;
        iSignal1 = 1'b0;
        iReady   = 1'b0;
        #1;
        checkReset("reset.init");
        @(posedge iClk);
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        stepClk();
        checkReset("reset.idle");

        // Round-robin with both requesting: 0, 1, 0.
        applyStimulus(2'b11, 8'hFF, 8'h00, 1'b0, 0);
        applyStimulus(2'b11, 8'hFF, 8'h00, 1'b1, 0);
        applyStimulus(2'b11, 8'hFF, 8'h00, 1'b0, 0);

        // Requester 1 alone with five cycles of backpressure; pointer then favours 0.
        applyStimulus(2'b10, 8'h00, 8'h3C, 1'b1, 5);

        // Abort: requester 0 drops its request on the bit-4 edge.
        iReq   = 2'b01;
        iReady = 1'b1;
        stepClk();
        for (int i = 0; i < 5; i++) begin
            iSignal0 = 1'b1;
            checkOutput("abort.grant",  32'(oGrant),  32'(2'b01));
            checkOutput("abort.bitIdx", 32'(oBitIdx), 32'(i));
            if (i == 4) begin
                iReq = 2'b00;
            end
            stepClk();
        end
        checkOutput("abort.pulse",  32'(oAbort),  32'(1'b1));
        checkOutput("abort.grant0", 32'(oGrant),  32'(2'b00));
        checkOutput("abort.valid",  32'(oValid),  32'(1'b0));
        checkOutput("abort.vector", 32'(oVector), 32'(8'h3C));
        checkOutput("abort.src",    32'(oSrc),    32'(1'b1));
        checkOutput("abort.bitIdx0", 32'(oBitIdx), 32'(3'd0));
        stepClk();
        iReady = 1'b0;
        checkOutput("abort.pulseEnd", 32'(oAbort), 32'(1'b0));
        checkOutput("abort.idle",     32'(oGrant), 32'(2'b00));

        // Pointer untouched by the abort: requester 0 still wins the tie.
        applyStimulus(2'b11, 8'hA5, 8'h5A, 1'b0, 0);

        // Asynchronous reset between edges while oBitIdx is 3.
        iReq = 2'b10;
        stepClk();
        for (int i = 0; i < 4; i++) begin
            iSignal1 = 1'b1;
            checkOutput("rstmid.bitIdx", 32'(oBitIdx), 32'(i));
            if (i < 3) begin
                stepClk();
            end
        end
        #2;
        iReset = 1'b1;
        #1;
        checkReset("rstmid.async");
        iReq = 2'b00;
        @(posedge iClk);
        #2;
        iReset = 1'b0;
        stepClk();
        checkReset("rstmid.after");

        // Fresh captures after reset: pointer back to requester 0.
        applyStimulus(2'b11, 8'hA5, 8'h0F, 1'b0, 2);
        applyStimulus(2'b01, 8'hA5, 8'h00, 1'b0, 0);
        iReq = 2'b00;
        stepClk();
        checkOutput("end.idle.grant", 32'(oGrant), 32'(2'b00));
        checkOutput("end.sbEmpty", 32'(sbQueue.size()), 32'(0));

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
